// File: rtl/sram2rw_fifo_ctrl_if.sv
// Producer/consumer stream bundle for sram2rw_fifo_ctrl.
// A word moves on a side only in a cycle where valid & ready are both high at the clock edge;
// valid must not depend on ready, and data is held stable while valid is high and ready is low.
interface sram2rw_fifo_ctrl_if #(
  parameter int DW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sram2rw_fifo_ctrl.sv
// FIFO controller for the two-port 128x4 SRAM macro: port 1 writes, port 2 reads, and a
// 2-entry output buffer hides the macro's one-cycle registered read latency.
module sram2rw_fifo_ctrl #(
  parameter int AW    = 7,
  parameter int DEPTH = 128,
  parameter int DW    = 4
) (
  input  logic                 CE,
  input  logic                 RSTB,
  sram2rw_fifo_ctrl_if.slave   strm,
  output logic [AW:0]          level,
  output logic [AW-1:0]        A1,
  output logic [DW-1:0]        I1,
  output logic                 CSB1,
  output logic                 WEB1,
  output logic                 OEB1,
  output logic [AW-1:0]        A2,
  output logic                 CSB2,
  output logic                 OEB2,
  output logic                 WEB2,
  input  logic [DW-1:0]        O2
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   scnt;
  logic          infl;
  logic [1:0]    ob;
  logic [DW-1:0] obuf [2];
  logic          ob_rd;
  logic          ob_wr;

  logic          push;
  logic          pop;
  logic          issue;
  logic [2:0]    occ_after;

  // Full/empty look only at committed SRAM words, so the obuf never stalls the write side.
  assign strm.in_ready  = (scnt != FULL);
  assign strm.out_valid = (ob != 2'd0);
  assign strm.out_data  = obuf[ob_rd];

  assign push = strm.in_valid & strm.in_ready & RSTB;
  assign pop  = strm.out_valid & strm.out_ready;

  // Buffer occupancy after this edge ignoring a new issue; issue only if a slot stays free.
  assign occ_after = {1'b0, ob} + {2'b00, infl} - {2'b00, pop};
  assign issue     = (scnt != '0) && (occ_after < 3'd2) && RSTB;

  assign level = scnt + (AW+1)'(infl) + (AW+1)'(ob);

  assign A1   = wptr;
  assign I1   = strm.in_data;
  assign CSB1 = ~push;
  assign WEB1 = ~push;
  assign OEB1 = 1'b1;

  assign A2   = rptr;
  assign CSB2 = ~issue;
  assign OEB2 = ~issue;
  assign WEB2 = 1'b1;

  always_ff @(posedge CE or negedge RSTB) begin
    if (!RSTB) begin
      wptr    <= '0;
      rptr    <= '0;
      scnt    <= '0;
      infl    <= 1'b0;
      ob      <= 2'd0;
      ob_rd   <= 1'b0;
      ob_wr   <= 1'b0;
      obuf[0] <= '0;
      obuf[1] <= '0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (issue)
        rptr <= rptr + 1'b1;
      infl <= issue;
      scnt <= scnt + (AW+1)'(push) - (AW+1)'(issue);
      // O2 is valid exactly one cycle after the issue, so capture on infl.
      if (infl) begin
        obuf[ob_wr] <= O2;
        ob_wr       <= ~ob_wr;
      end
      if (pop)
        ob_rd <= ~ob_rd;
      ob <= ob + {1'b0, infl} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_sram2rw_fifo_ctrl.sv
// Directed and random stimulus for sram2rw_fifo_ctrl with a behavioural 128x4 two-port macro
// and an expected-word queue scoreboard.
module tb_sram2rw_fifo_ctrl;

  logic       CE;
  logic       RSTB;
  logic [7:0] level;
  logic [6:0] A1;
  logic [6:0] A2;
  logic [3:0] I1;
  logic [3:0] O2;
  logic       CSB1, WEB1, OEB1, CSB2, OEB2, WEB2;

  sram2rw_fifo_ctrl_if #(.DW(4)) sif ();

  sram2rw_fifo_ctrl #(.AW(7), .DEPTH(128), .DW(4)) dut (
    .CE    (CE),
    .RSTB  (RSTB),
    .strm  (sif),
    .level (level),
    .A1    (A1),
    .I1    (I1),
    .CSB1  (CSB1),
    .WEB1  (WEB1),
    .OEB1  (OEB1),
    .A2    (A2),
    .CSB2  (CSB2),
    .OEB2  (OEB2),
    .WEB2  (WEB2),
    .O2    (O2)
  );

  // Behavioural macro: write at the edge, registered read data one cycle later.
  logic [3:0] mem [128];
  always @(posedge CE) begin
    if (!CSB1 && !WEB1)
      mem[A1] <= I1;
    if (!CSB2 && !OEB2)
      O2 <= mem[A2];
  end

  // clock / reset
  initial begin
    CE = 1'b0;
    forever #5 CE = ~CE;
  end

  int n_checks = 0;
  int n_bad    = 0;
  int pushes   = 0;
  int pops     = 0;
  logic [3:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: settle inputs, score the handshakes that commit at the edge, then check level.
  task automatic cycle();
    logic push, pop;
    #1;
    push = RSTB & sif.in_valid & sif.in_ready;
    pop  = RSTB & sif.out_valid & sif.out_ready;
    if (!CSB1 && !CSB2)
      check_eq("same_addr", 32'(A1 == A2), 32'd0);
    if (pop) begin
      if (exp_q.size() == 0)
        check_eq("pop_on_empty", 32'(exp_q.size()), 32'd1);
      else
        check_eq("data", 32'(sif.out_data), 32'(exp_q.pop_front()));
      pops++;
    end
    if (push) begin
      exp_q.push_back(sif.in_data);
      pushes++;
    end
    @(posedge CE);
    #1;
    check_eq("level", 32'(level), 32'(exp_q.size()));
  endtask

  task automatic drain(input string tag);
    int g;
    sif.in_valid  = 1'b0;
    sif.out_ready = 1'b1;
    g = 0;
    while ((exp_q.size() != 0 || sif.out_valid) && g < 400) begin
      cycle();
      g++;
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int nc, base, pbase, g;

    RSTB          = 1'b0;
    sif.in_valid  = 1'b0;
    sif.in_data   = '0;
    sif.out_ready = 1'b0;
    repeat (3) @(posedge CE);
    #1;
    check_eq("rst_out_valid", 32'(sif.out_valid), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_in_ready", 32'(sif.in_ready), 32'd1);
    check_eq("rst_csb1", 32'(CSB1), 32'd1);
    check_eq("rst_csb2", 32'(CSB2), 32'd1);
    check_eq("rst_oeb1_web2", 32'({OEB1, WEB2}), 32'd3);
    #2;
    RSTB = 1'b1;
    @(posedge CE);
    #1;

    // single word 0x5
    sif.in_valid  = 1'b1;
    sif.in_data   = 4'h5;
    sif.out_ready = 1'b1;
    #1;
    check_eq("w1_a1", 32'(A1), 32'd0);
    check_eq("w1_csb1_web1", 32'({CSB1, WEB1}), 32'd0);
    check_eq("w1_no_issue", 32'(CSB2), 32'd1);
    cycle();
    sif.in_valid = 1'b0;
    #1;
    check_eq("w1_csb2", 32'({CSB2, OEB2}), 32'd0);
    check_eq("w1_a2", 32'(A2), 32'd0);
    cycle();
    check_eq("w1_not_yet_valid", 32'(sif.out_valid), 32'd0);
    cycle();
    check_eq("w1_out_valid", 32'(sif.out_valid), 32'd1);
    check_eq("w1_out_data", 32'(sif.out_data), 32'h5);
    cycle();
    check_eq("w1_level_after", 32'(level), 32'd0);

    // 300-word stream, both sides always ready
    base  = pushes;
    pbase = pops;
    nc    = 0;
    sif.out_ready = 1'b1;
    while ((pushes - base) < 300 && nc < 400) begin
      sif.in_valid = 1'b1;
      sif.in_data  = 4'(pushes - base);
      cycle();
      nc++;
    end
    sif.in_valid = 1'b0;
    while (exp_q.size() != 0 && nc < 400) begin
      cycle();
      nc++;
    end
    check_eq("stream_cycles", 32'(nc), 32'd303);
    check_eq("stream_pops", 32'(pops - pbase), 32'd300);

    // fill with consumer stalled
    base = pushes;
    g    = 0;
    sif.out_ready = 1'b0;
    sif.in_valid  = 1'b1;
    while (sif.in_ready && g < 300) begin
      sif.in_data = 4'($urandom_range(0, 15));
      cycle();
      g++;
    end
    check_eq("fill_pushes", 32'(pushes - base), 32'd130);
    check_eq("fill_level", 32'(level), 32'd130);
    check_eq("fill_in_ready", 32'(sif.in_ready), 32'd0);
    #1;
    check_eq("full_no_write", 32'(CSB1), 32'd1);
    cycle();
    cycle();
    check_eq("full_level_hold", 32'(level), 32'd130);
    sif.out_ready = 1'b1;
    #1;
    check_eq("full_pop_issue", 32'(CSB2), 32'd0);
    check_eq("full_pop_in_ready", 32'(sif.in_ready), 32'd0);
    cycle();
    sif.out_ready = 1'b0;
    sif.in_valid  = 1'b0;
    check_eq("after_issue_in_ready", 32'(sif.in_ready), 32'd1);
    check_eq("after_issue_level", 32'(level), 32'd129);
    drain("fill_drain");

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      sif.in_valid  = 1'($urandom_range(0, 1));
      sif.out_ready = 1'($urandom_range(0, 1));
      sif.in_data   = 4'($urandom_range(0, 15));
      cycle();
    end
    drain("random_drain");

    // reset mid-stream at level 40
    g = 0;
    sif.out_ready = 1'b0;
    sif.in_valid  = 1'b1;
    while (level != 8'd40 && g < 100) begin
      sif.in_data = 4'($urandom_range(0, 15));
      cycle();
      g++;
    end
    check_eq("pre_rst_level", 32'(level), 32'd40);
    sif.in_valid = 1'b0;
    #2;
    RSTB = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 32'(sif.out_valid), 32'd0);
    check_eq("mid_rst_level", 32'(level), 32'd0);
    check_eq("mid_rst_in_ready", 32'(sif.in_ready), 32'd1);
    check_eq("mid_rst_strobes", 32'({CSB1, WEB1, CSB2, OEB2}), 32'hF);
    exp_q.delete();
    @(posedge CE);
    #3;
    RSTB = 1'b1;
    @(posedge CE);
    #1;
    sif.in_valid  = 1'b1;
    sif.in_data   = 4'hA;
    sif.out_ready = 1'b1;
    #1;
    check_eq("post_rst_a1", 32'(A1), 32'd0);
    check_eq("post_rst_csb1", 32'(CSB1), 32'd0);
    cycle();
    sif.in_valid = 1'b0;
    #1;
    check_eq("post_rst_a2", 32'(A2), 32'd0);
    pbase = pops;
    drain("post_rst_drain");
    check_eq("post_rst_readback", 32'(pops - pbase), 32'd1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
